// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, constants and checksum helper for the UART command-frame decoder.
// A frame is SYNC, OP, ADDR[23:16], ADDR[15:8], ADDR[7:0], LEN[15:8], LEN[7:0], CHK.
package uart_cmd_pkg;

   typedef enum logic [3:0] {
      ST_HUNT = 4'd0,
      ST_OP   = 4'd1,
      ST_A2   = 4'd2,
      ST_A1   = 4'd3,
      ST_A0   = 4'd4,
      ST_L1   = 4'd5,
      ST_L0   = 4'd6,
      ST_CHK  = 4'd7,
      ST_HOLD = 4'd8
   } cmdState_e;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int         FRAME_LEN    = 8;

   localparam logic [7:0] OP_READ  = 8'h01;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_ID    = 8'h03;

   // CHK byte is the XOR of every byte between SYNC and CHK.
   function automatic logic [7:0] frameChecksum(input logic [7:0]  op,
                                                input logic [23:0] addr,
                                                input logic [15:0] len);
      return op ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ len[15:8] ^ len[7:0];
   endfunction

   // States in which a frame is partially received and the gap limit applies.
   function automatic logic inFrame(input cmdState_e s);
      return s inside {ST_OP, ST_A2, ST_A1, ST_A0, ST_L1, ST_L0, ST_CHK};
   endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Saturating inter-byte gap counter; expired flags the edge that would bring the
// count to LIMIT while enabled and not being cleared.
module uart_cmd_timer #(
   parameter int LIMIT = 2700
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW   = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] MAX  = CW'(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count != MAX) begin
         count <= count + 1'b1;
      end
   end

   // A clear in the same cycle always wins over expiry.
   assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes 8-byte SYNC-framed commands from a UART byte stream and presents them
// on a valid/ready port, with one-cycle error pulses for checksum, timeout and overrun.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 2700,
   parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rxData,
   input  logic        rxValid,
   output logic        cmdValid,
   input  logic        cmdReady,
   output logic [7:0]  cmdOp,
   output logic [23:0] cmdAddr,
   output logic [15:0] cmdLen,
   output logic        errChecksum,
   output logic        errTimeout,
   output logic        errOverrun,
   output logic        busy
);

   // Command handshake: cmdValid rises the cycle after a good CHK byte and stays
   // high with cmdOp/cmdAddr/cmdLen frozen until a cycle where cmdValid && cmdReady;
   // that edge completes the transfer and cmdValid drops in the next cycle.

   cmdState_e   state;
   cmdState_e   stateNext;
   cmdState_e   fieldNext;

   logic [7:0]  opSh;
   logic [23:0] addrSh;
   logic [15:0] lenSh;

   logic        gapExpired;
   logic        fieldState;
   logic        isSync;
   logic        chkMatch;
   logic        loadCmd;
   logic        chkErrNext;
   logic        toErrNext;
   logic        ovrErrNext;

   assign fieldState = inFrame(state);
   assign isSync     = rxValid && (rxData == SYNC_BYTE);
   assign chkMatch   = (rxData == frameChecksum(opSh, addrSh, lenSh));

   uart_cmd_timer #(
      .LIMIT(TIMEOUT_CYCLES)
   ) gapTimer (
      .clk    (clk),
      .rst    (rst),
      .clear  (rxValid),
      .enable (fieldState),
      .expired(gapExpired)
   );

   always_comb begin
      fieldNext = ST_HUNT;
      case (state)
         ST_OP:   fieldNext = ST_A2;
         ST_A2:   fieldNext = ST_A1;
         ST_A1:   fieldNext = ST_A0;
         ST_A0:   fieldNext = ST_L1;
         ST_L1:   fieldNext = ST_L0;
         ST_L0:   fieldNext = ST_CHK;
         default: fieldNext = ST_HUNT;
      endcase
   end

   always_comb begin
      stateNext  = state;
      loadCmd    = 1'b0;
      chkErrNext = 1'b0;
      toErrNext  = 1'b0;
      ovrErrNext = 1'b0;
      case (state)
         ST_HUNT: begin
            if (isSync) stateNext = ST_OP;
         end
         // A SYNC value inside a frame is plain data; only the byte position matters.
         ST_OP, ST_A2, ST_A1, ST_A0, ST_L1, ST_L0: begin
            if (rxValid) begin
               stateNext = fieldNext;
            end else if (gapExpired) begin
               stateNext = ST_HUNT;
               toErrNext = 1'b1;
            end
         end
         ST_CHK: begin
            if (rxValid) begin
               if (chkMatch) begin
                  stateNext = ST_HOLD;
                  loadCmd   = 1'b1;
               end else begin
                  stateNext  = ST_HUNT;
                  chkErrNext = 1'b1;
               end
            end else if (gapExpired) begin
               stateNext = ST_HUNT;
               toErrNext = 1'b1;
            end
         end
         ST_HOLD: begin
            // A byte arriving on the handshake edge is already a HUNT byte.
            if (cmdReady) begin
               stateNext = isSync ? ST_OP : ST_HUNT;
            end else if (rxValid) begin
               ovrErrNext = 1'b1;
            end
         end
         default: stateNext = ST_HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_HUNT;
         errChecksum <= 1'b0;
         errTimeout  <= 1'b0;
         errOverrun  <= 1'b0;
         cmdOp       <= '0;
         cmdAddr     <= '0;
         cmdLen      <= '0;
      end else begin
         state       <= stateNext;
         errChecksum <= chkErrNext;
         errTimeout  <= toErrNext;
         errOverrun  <= ovrErrNext;
         if (loadCmd) begin
            cmdOp   <= opSh;
            cmdAddr <= addrSh;
            cmdLen  <= lenSh;
         end
      end
   end

   // Shadows collect the frame so the visible command only changes on a good CHK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opSh   <= '0;
         addrSh <= '0;
         lenSh  <= '0;
      end else if (rxValid) begin
         case (state)
            ST_OP:   opSh           <= rxData;
            ST_A2:   addrSh[23:16]  <= rxData;
            ST_A1:   addrSh[15:8]   <= rxData;
            ST_A0:   addrSh[7:0]    <= rxData;
            ST_L1:   lenSh[15:8]    <= rxData;
            ST_L0:   lenSh[7:0]     <= rxData;
            default: ;
         endcase
      end
   end

   assign cmdValid = (state == ST_HOLD);
   assign busy     = (state != ST_HUNT);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: directed frame scenarios followed by
// randomized frame streams, with expectations derived from the frame rules.
module tb_uart_cmd_decoder;
   import uart_cmd_pkg::*;

   localparam int         TO   = 40;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         W    = 50;
   localparam logic [1:0] EV_CMD = 2'd0;
   localparam logic [1:0] EV_CHK = 2'd1;
   localparam logic [1:0] EV_TO  = 2'd2;
   localparam logic [1:0] EV_OVR = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        cmdValid;
   logic        cmdReady;
   logic [7:0]  cmdOp;
   logic [23:0] cmdAddr;
   logic [15:0] cmdLen;
   logic        errChecksum;
   logic        errTimeout;
   logic        errOverrun;
   logic        busy;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   uart_cmd_decoder #(
      .TIMEOUT_CYCLES(TO),
      .SYNC_BYTE     (SYNC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxData     (rxData),
      .rxValid    (rxValid),
      .cmdValid   (cmdValid),
      .cmdReady   (cmdReady),
      .cmdOp      (cmdOp),
      .cmdAddr    (cmdAddr),
      .cmdLen     (cmdLen),
      .errChecksum(errChecksum),
      .errTimeout (errTimeout),
      .errOverrun (errOverrun),
      .busy       (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // ---------------- reference model helpers ----------------
   function automatic logic [7:0] ref_chk(input logic [7:0] op, input logic [23:0] addr,
                                          input logic [15:0] len);
      logic [7:0] acc;
      acc = 8'h00;
      acc = acc ^ op;
      for (int i = 0; i < 3; i++) acc = acc ^ addr[8*i +: 8];
      for (int i = 0; i < 2; i++) acc = acc ^ len[8*i +: 8];
      return acc;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   task automatic push_cmd(input logic [7:0] op, input logic [23:0] addr, input logic [15:0] len);
      exp_q.push_back({EV_CMD, op, addr, len});
   endtask

   task automatic push_err(input logic [1:0] kind);
      exp_q.push_back({kind, 48'h0});
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rxData  = b;
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [23:0] addr, input logic [15:0] len,
                             input logic [7:0] chk, input int first, input int last, input int max_gap);
      logic [7:0] b [8];
      b[0] = SYNC;           b[1] = op;
      b[2] = addr[23:16];    b[3] = addr[15:8];  b[4] = addr[7:0];
      b[5] = len[15:8];      b[6] = len[7:0];    b[7] = chk;
      for (int i = first; i <= last; i++) begin
         if (i > first) idle($urandom_range(0, max_gap));
         send_byte(b[i]);
      end
   endtask

   task automatic expect_cmd_now(input string name, input logic [7:0] op, input logic [23:0] addr,
                                 input logic [15:0] len);
      check({name, "_valid"}, cmdValid, 1'b1);
      check({name, "_op"},    cmdOp,    op);
      check({name, "_addr"},  cmdAddr,  addr);
      check({name, "_len"},   cmdLen,   len);
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic sb_event(input logic [1:0] kind, input logic [47:0] data);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL sb_unexpected: got event kind %0d data %0h, expected none at %0t",
                  kind, data, $time);
      end else begin
         e = exp_q.pop_front();
         check("sb_kind", kind, e[49:48]);
         check("sb_data", data, e[47:0]);
      end
   endtask

   logic        hold_prev = 1'b0;
   logic [47:0] prev_cmd;

   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         hold_prev = 1'b0;
      end else begin
         if (errChecksum) sb_event(EV_CHK, 48'h0);
         if (errTimeout)  sb_event(EV_TO,  48'h0);
         if (errOverrun)  sb_event(EV_OVR, 48'h0);
         if (cmdValid && cmdReady) sb_event(EV_CMD, {cmdOp, cmdAddr, cmdLen});
         if (hold_prev) check("hold_stable", {cmdValid, cmdOp, cmdAddr, cmdLen}, {1'b1, prev_cmd});
         hold_prev = cmdValid && !cmdReady;
         prev_cmd  = {cmdOp, cmdAddr, cmdLen};
      end
   end

   // ---------------- random stimulus ----------------
   task automatic random_iteration();
      int         kind;
      int         n_garb;
      int         pre;
      int         n_ovr;
      int         last;
      logic [7:0] op;
      logic [23:0] addr;
      logic [15:0] len;
      logic [7:0] b;
      logic [7:0] chk;
      kind   = $urandom_range(0, 3);
      n_garb = $urandom_range(0, 3);
      op     = 8'($urandom);
      addr   = 24'($urandom);
      len    = 16'($urandom);
      chk    = ref_chk(op, addr, len);
      for (int g = 0; g < n_garb; g++) begin
         b = 8'($urandom_range(0, 255));
         if (b == SYNC) b = 8'h3C;
         idle($urandom_range(0, 3));
         send_byte(b);
      end
      idle($urandom_range(0, 3));
      if (kind <= 1) begin
         pre   = $urandom_range(0, 1);
         n_ovr = (pre != 0) ? 0 : $urandom_range(0, 2);
         for (int k = 0; k < n_ovr; k++) push_err(EV_OVR);
         push_cmd(op, addr, len);
         cmdReady = (pre != 0);
         send_frame(op, addr, len, chk, 0, 7, 5);
         if (pre == 0) begin
            idle($urandom_range(0, 3));
            for (int k = 0; k < n_ovr; k++) begin
               send_byte(8'($urandom_range(0, 255)));
               idle($urandom_range(1, 2));
            end
            cmdReady = 1'b1;
            tick();
         end
      end else if (kind == 2) begin
         push_err(EV_CHK);
         send_frame(op, addr, len, chk ^ 8'($urandom_range(1, 255)), 0, 7, 5);
      end else begin
         last = $urandom_range(0, 6);
         push_err(EV_TO);
         send_frame(op, addr, len, chk, 0, last, 5);
         idle(TO + 2);
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst      = 1'b1;
      rxValid  = 1'b0;
      rxData   = 8'h00;
      cmdReady = 1'b0;
      idle(3);
      check("rst_busy",     busy,        1'b0);
      check("rst_cmdValid", cmdValid,    1'b0);
      check("rst_errs",     {errChecksum, errTimeout, errOverrun}, 3'b000);
      check("rst_cmd",      {cmdOp, cmdAddr, cmdLen}, 48'h0);
      rst = 1'b0;
      idle(2);

      // Good frame. The XOR of 01 12 34 56 00 10 is 0x61.
      cmdReady = 1'b1;
      push_cmd(8'h01, 24'h123456, 16'h0010);
      send_frame(8'h01, 24'h123456, 16'h0010, 8'h61, 0, 6, 0);
      check("good_pre_valid", cmdValid, 1'b0);
      check("good_pre_busy",  busy,     1'b1);
      send_byte(8'h61);
      expect_cmd_now("good", 8'h01, 24'h123456, 16'h0010);
      tick();
      check("good_post_valid", cmdValid, 1'b0);
      check("good_post_busy",  busy,     1'b0);
      idle(2);

      // Same frame with a wrong CHK byte.
      push_err(EV_CHK);
      send_frame(8'h01, 24'h123456, 16'h0010, 8'h60, 0, 7, 0);
      check("badchk_pulse", errChecksum, 1'b1);
      check("badchk_valid", cmdValid,    1'b0);
      check("badchk_busy",  busy,        1'b0);
      tick();
      check("badchk_pulse_end", errChecksum, 1'b0);
      check("badchk_valid2",    cmdValid,    1'b0);
      idle(2);

      // Inter-byte timeout after A5 02.
      push_err(EV_TO);
      send_frame(8'h02, 24'h0, 16'h0, 8'h0, 0, 1, 0);
      idle(TO - 1);
      check("to_early", errTimeout, 1'b0);
      check("to_early_busy", busy, 1'b1);
      tick();
      check("to_pulse", errTimeout, 1'b1);
      check("to_hunt",  busy,       1'b0);
      check("to_cmd_kept", {cmdOp, cmdAddr, cmdLen}, {8'h01, 24'h123456, 16'h0010});
      tick();
      check("to_pulse_end", errTimeout, 1'b0);
      idle(2);

      // A byte landing on the expiry cycle keeps the frame alive.
      push_cmd(OP_WRITE, 24'h123456, 16'h0010);
      send_frame(OP_WRITE, 24'h123456, 16'h0010, 8'h0, 0, 1, 0);
      idle(TO - 1);
      send_byte(8'h12);
      check("to_suppr_err",  errTimeout, 1'b0);
      check("to_suppr_busy", busy,       1'b1);
      send_frame(OP_WRITE, 24'h123456, 16'h0010, ref_chk(OP_WRITE, 24'h123456, 16'h0010), 3, 7, 0);
      expect_cmd_now("to_suppr", OP_WRITE, 24'h123456, 16'h0010);
      tick();
      idle(2);

      // Overrun while holding, then handshake coincident with a new SYNC.
      cmdReady = 1'b0;
      push_err(EV_OVR);
      push_cmd(OP_ID, 24'hABCDEF, 16'h1234);
      push_cmd(OP_READ, 24'h000100, 16'h0004);
      send_frame(OP_ID, 24'hABCDEF, 16'h1234, ref_chk(OP_ID, 24'hABCDEF, 16'h1234), 0, 7, 2);
      expect_cmd_now("hold", OP_ID, 24'hABCDEF, 16'h1234);
      idle(2);
      send_byte(8'h00);
      check("ovr_pulse", errOverrun, 1'b1);
      expect_cmd_now("ovr_hold", OP_ID, 24'hABCDEF, 16'h1234);
      tick();
      check("ovr_pulse_end", errOverrun, 1'b0);
      cmdReady = 1'b1;
      rxData   = SYNC;
      rxValid  = 1'b1;
      tick();
      rxValid  = 1'b0;
      check("hs_sync_valid", cmdValid,   1'b0);
      check("hs_sync_busy",  busy,       1'b1);
      check("hs_sync_novr",  errOverrun, 1'b0);
      send_frame(OP_READ, 24'h000100, 16'h0004, ref_chk(OP_READ, 24'h000100, 16'h0004), 1, 7, 0);
      expect_cmd_now("hs_sync_next", OP_READ, 24'h000100, 16'h0004);
      tick();
      idle(2);

      // Leading garbage is ignored silently.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      check("garb_busy", busy, 1'b0);
      check("garb_errs", {errChecksum, errTimeout, errOverrun}, 3'b000);
      push_cmd(OP_WRITE, 24'h00BEEF, 16'h0020);
      send_frame(OP_WRITE, 24'h00BEEF, 16'h0020, ref_chk(OP_WRITE, 24'h00BEEF, 16'h0020), 0, 7, 1);
      expect_cmd_now("garb", OP_WRITE, 24'h00BEEF, 16'h0020);
      tick();
      idle(2);

      // Asynchronous reset mid-frame, then a frame full of SYNC-valued data.
      send_frame(8'h01, 24'h123456, 16'h0010, 8'h61, 0, 2, 0);
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("arst_busy",  busy,     1'b0);
      check("arst_valid", cmdValid, 1'b0);
      check("arst_cmd",   {cmdOp, cmdAddr, cmdLen}, 48'h0);
      check("arst_errs",  {errChecksum, errTimeout, errOverrun}, 3'b000);
      tick();
      rst = 1'b0;
      idle(1);
      push_cmd(OP_ID, 24'hA5A5A5, 16'hA5A5);
      send_frame(OP_ID, 24'hA5A5A5, 16'hA5A5, ref_chk(OP_ID, 24'hA5A5A5, 16'hA5A5), 0, 7, 0);
      expect_cmd_now("post_rst", OP_ID, 24'hA5A5A5, 16'hA5A5);
      tick();
      idle(2);

      for (int it = 0; it < 40; it++) random_iteration();

      cmdReady = 1'b1;
      idle(TO + 10);
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
